instr_decode_stage: RTL

//  Downstream neighbour of the instruction fetch stage. Accepts {pc, 16-bit instruction} via valid/ready,

---
 rtl/instr_decode_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - instruction decode stage with skid FIFO, registered decoded bundle, flush, perf counters
//
// Purpose: accepts {pc, instruction} from fetch, buffers it in a DEPTH-entry FIFO,
// decodes the head entry and registers the decoded bundle for the execute stage.
// Optional feature macro: ID_PERF_CNT_EN (builds saturating perf counters).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discard buffered and output instructions
//   if_valid/if_ready        fetch handshake; if_pc, if_instr carry the instruction
//   id_valid/id_ready        execute handshake for the decoded bundle
//   id_pc, id_opcode, id_rd, id_rs, id_rt, id_imm, id_alu_op   decoded fields
//   id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal   controls
//   perf_decoded, perf_stall bundles accepted / stalled cycles (0 when not built)
module instr_decode_stage #(
    parameter int IW    = 16,
    parameter int AW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [AW-1:0] if_pc,
    input  logic [IW-1:0] if_instr,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [AW-1:0] id_pc,
    output logic [3:0]    id_opcode,
    output logic [3:0]    id_rd,
    output logic [3:0]    id_rs,
    output logic [3:0]    id_rt,
    output logic [15:0]   id_imm,
    output logic [2:0]    id_alu_op,
    output logic          id_reg_write,
    output logic          id_mem_read,
    output logic          id_mem_write,
    output logic          id_branch,
    output logic          id_jump,
    output logic          id_illegal,
    output logic [15:0]   perf_decoded,
    output logic [15:0]   perf_stall
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int PW   = IDXW + 1;
    localparam int EW   = AW + IW;
    // pc, opcode, rd, rs, rt, imm, alu_op, 6 control bits
    localparam int BW   = AW + 16 + 16 + 3 + 6;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          id_valid_q, id_valid_d;
    logic [BW-1:0] bnd_q, bnd_d;

    logic          full, empty, enq, deq;
    logic [EW-1:0] head;
    logic [3:0]    op;
    logic [2:0]    dec_alu;
    logic          dec_rw, dec_mr, dec_mw, dec_br, dec_jp, dec_ill;
    logic [BW-1:0] dec_bundle;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[IDXW-1:0] == rd_ptr_q[IDXW-1:0]);

    // if_ready comes only from registered pointers, so a dequeue in the same
    // cycle never opens a slot for an enqueue while full.
    assign if_ready = !full;
    assign enq      = if_valid && if_ready && !flush;
    // The output register is refilled only from the buffer (never bypassed).
    assign deq      = !empty && (!id_valid_q || id_ready) && !flush;

    assign head = mem_q[rd_ptr_q[IDXW-1:0]];
    assign op   = head[15:12];

    always_comb begin
        dec_alu = 3'd0;
        dec_rw  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_br  = 1'b0;
        dec_jp  = 1'b0;
        dec_ill = 1'b0;
        if (!op[3]) begin
            dec_rw  = 1'b1;
            dec_alu = op[2:0];
        end else begin
            case (op[2:0])
                3'd0:    begin dec_rw = 1'b1; dec_mr = 1'b1; end
                3'd1:    dec_mw = 1'b1;
                3'd2:    dec_br = 1'b1;
                3'd3:    dec_jp = 1'b1;
                default: dec_ill = 1'b1;
            endcase
        end
    end

    assign dec_bundle = {head[EW-1:IW], op, head[11:8], head[7:4], head[3:0],
                         {{12{head[3]}}, head[3:0]}, dec_alu,
                         dec_rw, dec_mr, dec_mw, dec_br, dec_jp, dec_ill};

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q + PW'(enq);
        rd_ptr_d   = rd_ptr_q + PW'(deq);
        id_valid_d = id_valid_q;
        bnd_d      = bnd_q;
        if (enq) begin
            mem_d[wr_ptr_q[IDXW-1:0]] = {if_pc, if_instr};
        end
        if (deq) begin
            id_valid_d = 1'b1;
            bnd_d      = dec_bundle;
        end else if (id_ready) begin
            id_valid_d = 1'b0;
        end
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            id_valid_q <= 1'b0;
            bnd_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            id_valid_q <= id_valid_d;
            bnd_q      <= bnd_d;
        end
    end

    assign id_valid = id_valid_q;
    assign {id_pc, id_opcode, id_rd, id_rs, id_rt, id_imm, id_alu_op,
            id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal} = bnd_q;

`ifdef ID_PERF_CNT_EN
    logic [15:0] perf_decoded_q, perf_decoded_d, perf_stall_q, perf_stall_d;

    // Saturating counters; flush deliberately leaves them untouched.
    always_comb begin
        perf_decoded_d = perf_decoded_q;
        perf_stall_d   = perf_stall_q;
        if (id_valid_q && id_ready && perf_decoded_q != 16'hFFFF) begin
            perf_decoded_d = perf_decoded_q + 16'd1;
        end
        if (id_valid_q && !id_ready && perf_stall_q != 16'hFFFF) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_decoded_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_decoded_q <= perf_decoded_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_stall   = perf_stall_q;
`else
    assign perf_decoded = 16'd0;
    assign perf_stall   = 16'd0;
`endif
endmodule
